// File: rtl/sqrt_arb_pkg.sv
// sqrt_arb_pkg: shared constants and tag type for the sqrt core arbiter
package sqrt_arb_pkg;
    localparam int SQRT_DATA_W   = 20;
    localparam int SQRT_RES_W    = 11;
    localparam int SQRT_CORE_LAT = 16;
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } sqrt_tag_t;
endpackage

// File: rtl/sqrt_arb_if.sv
// sqrt_arb_if: requester, response and core-side signals of the sqrt arbiter
interface sqrt_arb_if import sqrt_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = SQRT_DATA_W,
    parameter int RES_W   = SQRT_RES_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         core_x_in;
    logic [RES_W-1:0]          core_x_out;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [RES_W-1:0]          resp_data;
    modport slave (
        input  req_valid, req_data, core_x_out,
        output req_ready, core_x_in, resp_valid, resp_data
    );
    modport master (
        output req_valid, req_data, core_x_out,
        input  req_ready, core_x_in, resp_valid, resp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with registered priority pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);
    localparam int W = $clog2(N);
    logic [W-1:0] ptr;
    // lowest overall request first, then overridden by the lowest at or above ptr
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int j = N - 1; j >= 0; j--)
            if (req[j]) begin
                grant_any = 1'b1;
                grant_idx = W'(j);
            end
        for (int j = N - 1; j >= 0; j--)
            if (req[j] && W'(j) >= ptr) grant_idx = W'(j);
        for (int j = 0; j < N; j++) grant[j] = grant_any && grant_idx == W'(j);
    end
    always_ff @(posedge clk)
        if (rst) ptr <= '0;
        else if (grant_any) ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: shares a pipelined sqrt core among requesters; SQRT_ARB_STATS_EN adds grant/wait statistics
module sqrt_arbiter import sqrt_arb_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = SQRT_DATA_W,
    parameter int RES_W    = SQRT_RES_W,
    parameter int CORE_LAT = SQRT_CORE_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    sqrt_arb_if.slave             bus,
`ifdef SQRT_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0] issue_cnt,
    output logic [15:0]           max_wait,
`endif
    output logic                  busy
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               gany;
    logic [DATA_W-1:0]  sel;
    logic [NUM_REQ-1:0] resp_nxt;
    sqrt_tag_t          tags [CORE_LAT+1];
    // grants are suppressed during reset so no transfer is silently dropped
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid & {NUM_REQ{!rst}}),
        .grant     (grant),
        .grant_idx (gidx),
        .grant_any (gany)
    );
    assign bus.req_ready = grant;
    always_comb begin
        sel = '0;
        for (int j = 0; j < NUM_REQ; j++)
            if (gidx == IW'(j)) sel = bus.req_data[j*DATA_W +: DATA_W];
        for (int j = 0; j < NUM_REQ; j++)
            resp_nxt[j] = tags[CORE_LAT].valid && tags[CORE_LAT].id == 3'(j);
        busy = |bus.resp_valid;
        for (int k = 0; k <= CORE_LAT; k++) busy = busy | tags[k].valid;
    end
    // the final tag stage lines up with core_x_out for the operand it tracks
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= CORE_LAT; k++) tags[k] <= '0;
            bus.core_x_in  <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
        end else begin
            tags[0] <= '{gany, 3'(gidx)};
            for (int k = 1; k <= CORE_LAT; k++) tags[k] <= tags[k-1];
            if (gany) bus.core_x_in <= sel;
            bus.resp_valid <= resp_nxt;
            if (tags[CORE_LAT].valid) bus.resp_data <= bus.core_x_out;
        end
    end
`ifdef SQRT_ARB_STATS_EN
    logic [15:0] wait_cnt [NUM_REQ];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
            issue_cnt <= '0;
            max_wait  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    wait_cnt[i] <= '0;
                    if (issue_cnt[i*16 +: 16] != 16'hFFFF) issue_cnt[i*16 +: 16] <= issue_cnt[i*16 +: 16] + 16'd1;
                    if (wait_cnt[i] > max_wait) max_wait <= wait_cnt[i];
                end else if (!bus.req_valid[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != 16'hFFFF) begin
                    wait_cnt[i] <= wait_cnt[i] + 16'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed checks of arbitration, latency, ordering and reset flush
module tb_sqrt_arbiter;
    import sqrt_arb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_chk = 0;
    int   n_err = 0;
    logic [10:0] pipe [16];
    logic [10:0] roots2 [4] = '{11'd0, 11'd1, 11'd1023, 11'd12};
`ifdef SQRT_ARB_STATS_EN
    logic [63:0] issue_cnt;
    logic [15:0] max_wait;
`endif
    sqrt_arb_if #(.NUM_REQ(4), .DATA_W(20), .RES_W(11)) bus();
    sqrt_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
`ifdef SQRT_ARB_STATS_EN
        .issue_cnt (issue_cnt),
        .max_wait  (max_wait),
`endif
        .busy      (busy)
    );
    always #5 clk = ~clk;
    function automatic logic [10:0] isqrt(logic [19:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return 11'(r);
    endfunction
    // behavioural 16-cycle sqrt core
    always @(posedge clk) begin
        pipe[0] <= isqrt(bus.core_x_in);
        for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.core_x_out = pipe[15];
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        tick();
        tick();
        bus.req_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_data", 32'(bus.resp_data), 0);
        chk("rst_xin", 32'(bus.core_x_in), 0);
        chk("rst_busy", 32'(busy), 0);
        bus.req_valid = '0;
        rst = 1'b0;
        // single request from requester 1
        tick();
        bus.req_data[20 +: 20] = 20'd400;
        bus.req_valid = 4'b0010;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        chk("t1_xin", 32'(bus.core_x_in), 400);
        chk("t1_busy", 32'(busy), 1);
        repeat (16) tick();
        chk("t1_early", 32'(bus.resp_valid), 0);
        tick();
        chk("t1_valid", 32'(bus.resp_valid), 32'b0010);
        chk("t1_data", 32'(bus.resp_data), 20);
        chk("t1_busy_resp", 32'(busy), 1);
        tick();
        chk("t1_pulse", 32'(bus.resp_valid), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_hold", 32'(bus.resp_data), 20);
        // all four requesters from reset
        do_reset();
        bus.req_data  = {20'd144, 20'hFFFFF, 20'd1, 20'd0};
        bus.req_valid = 4'hF;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("t2_grant", 32'(bus.req_ready), 32'(1 << g));
            tick();
            bus.req_valid[g] = 1'b0;
        end
        repeat (14) tick();
        for (int g = 0; g < 4; g++) begin
            chk("t2_valid", 32'(bus.resp_valid), 32'(1 << g));
            chk("t2_data", 32'(bus.resp_data), 32'(roots2[g]));
            tick();
        end
        chk("t2_done", 32'(bus.resp_valid), 0);
        // requesters 0 and 2 alternate
        bus.req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_grant", 32'(bus.req_ready), (k % 2 == 1) ? 32'b0100 : 32'b0001);
            tick();
        end
        bus.req_valid = '0;
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("t3_drain", 32'(busy), 0);
        // requester 3 alone, back to back
        bus.req_valid = 4'b1000;
        for (int n = 0; n < 8; n++) begin
            bus.req_data[60 +: 20] = 20'((100 + n) * (100 + n));
            #1;
            chk("t4_grant", 32'(bus.req_ready), 32'b1000);
            tick();
        end
        bus.req_valid = '0;
        repeat (10) tick();
        for (int n = 0; n < 8; n++) begin
            chk("t4_valid", 32'(bus.resp_valid), 32'b1000);
            chk("t4_data", 32'(bus.resp_data), 32'(100 + n));
            tick();
        end
        chk("t4_done", 32'(bus.resp_valid), 0);
        // reset with five operands in flight
        bus.req_data[19:0] = 20'd81;
        bus.req_valid = 4'b0001;
        repeat (5) tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy_clr", 32'(busy), 0);
        for (int i = 0; i < 18; i++) begin
            chk("t5_quiet", 32'(bus.resp_valid), 0);
            tick();
        end
        chk("t5_busy", 32'(busy), 0);
        chk("t5_data", 32'(bus.resp_data), 0);
        bus.req_valid = 4'hF;
        #1;
        chk("t5_ptr", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
`ifdef SQRT_ARB_STATS_EN
        do_reset();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        chk("t6_cnt1_first", 32'(issue_cnt[31:16]), 1);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t6_grant", 32'(bus.req_ready), 32'(1 << ((k + 2) % 4)));
            tick();
            bus.req_valid[(k + 2) % 4] = 1'b0;
        end
        chk("t6_max_wait", 32'(max_wait), 3);
        chk("t6_cnt1", 32'(issue_cnt[31:16]), 2);
        chk("t6_cnt0", 32'(issue_cnt[15:0]), 1);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
